// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 BIST sequencer.
package c17_bist_pkg;

  localparam int unsigned LFSR_W = 5;
  localparam int unsigned OUT_W  = 2;

  // Fibonacci taps for x^5+x^3+1 in a shift-left register (feedback = s[4]^s[1])
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10010;

  localparam logic [15:0]       DEF_MISR_POLY = 16'h1021;
  localparam logic [15:0]       DEF_MISR_SEED = 16'h0000;
  localparam logic [LFSR_W-1:0] DEF_LFSR_SEED = 5'h01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/c17_misr.sv
// Galois MISR compacting the 2-bit c17 response into a signature.
module c17_misr
  import c17_bist_pkg::*;
#(
  parameter int unsigned        MISR_W    = 16,
  parameter logic [MISR_W-1:0]  MISR_POLY = MISR_W'(DEF_MISR_POLY),
  parameter logic [MISR_W-1:0]  MISR_SEED = MISR_W'(DEF_MISR_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  input  logic [OUT_W-1:0]  data,
  output logic [MISR_W-1:0] sig,
  output logic [MISR_W-1:0] sig_nxt_c
);

  // Next value is exported so the top can judge pass in the same edge that finishes the run
  always_comb begin
    sig_nxt_c = sig;
    if (clear) begin
      sig_nxt_c = MISR_SEED;
    end else if (step) begin
      sig_nxt_c = {sig[MISR_W-2:0], 1'b0}
                ^ (sig[MISR_W-1] ? MISR_POLY : '0)
                ^ MISR_W'(data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= MISR_SEED;
    end else begin
      sig <= sig_nxt_c;
    end
  end

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST sequencer for a registered c17 core: LFSR patterns, MISR compaction, golden compare.
// Optional C17_BIST_FAULT_INJ_EN adds a fault_inj port XORed into the compacted response.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int unsigned        CNT_W     = 8,
  parameter int unsigned        MISR_W    = 16,
  parameter logic [MISR_W-1:0]  MISR_POLY = MISR_W'(DEF_MISR_POLY),
  parameter logic [LFSR_W-1:0]  LFSR_SEED = DEF_LFSR_SEED,
  parameter logic [MISR_W-1:0]  MISR_SEED = MISR_W'(DEF_MISR_SEED),
  parameter int unsigned        PIPE_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  pat_count,
  input  logic [MISR_W-1:0] golden_sig,
  output logic [LFSR_W-1:0] dut_in,
  output logic              dut_en,
  input  logic [OUT_W-1:0]  dut_out,
`ifdef C17_BIST_FAULT_INJ_EN
  input  logic [OUT_W-1:0]  fault_inj,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] sig
);

  // An all-zero seed would lock the LFSR
  localparam logic [LFSR_W-1:0] LFSR_INIT = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  state_t              state, state_nxt;
  logic                accept;
  logic [CNT_W-1:0]    cnt;
  logic [LFSR_W-1:0]   lfsr;
  logic [PIPE_LAT-1:0] vpipe, vpipe_nxt;
  logic                misr_step;
  logic [OUT_W-1:0]    comp_data;
  logic [MISR_W-1:0]   sig_nxt;

  assign dut_in = lfsr;

`ifdef C17_BIST_FAULT_INJ_EN
  assign comp_data = dut_out ^ fault_inj;
`else
  assign comp_data = dut_out;
`endif

  // Tail of the valid pipe marks the cycle whose dut_out belongs to a pattern of this run
  assign misr_step = vpipe[PIPE_LAT-1] && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    vpipe_nxt = PIPE_LAT'({vpipe, (state == RUN)});
    case (state)
      IDLE, DONE: begin
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = (pat_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (vpipe_nxt == '0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Pattern generator, counter, valid pipe and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr   <= LFSR_INIT;
      cnt    <= '0;
      vpipe  <= '0;
      dut_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else begin
      if (accept) begin
        lfsr <= LFSR_INIT;
        cnt  <= pat_count;
      end else if (state == RUN) begin
        lfsr <= lfsr_next(lfsr);
        cnt  <= cnt - CNT_W'(1);
      end
      vpipe  <= abort ? '0 : vpipe_nxt;
      dut_en <= (state_nxt == RUN);
      busy   <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done   <= (state_nxt == DONE);
      if ((state_nxt == DONE) && ((state != DONE) || accept)) begin
        pass <= (sig_nxt == golden_sig);
      end else if (state_nxt != DONE) begin
        pass <= 1'b0;
      end
    end
  end

  c17_misr #(
    .MISR_W    (MISR_W),
    .MISR_POLY (MISR_POLY),
    .MISR_SEED (MISR_SEED)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .step      (misr_step),
    .data      (comp_data),
    .sig       (sig),
    .sig_nxt_c (sig_nxt)
  );

endmodule
